// File: rtl/redmule_pkg.sv
// Shared types and constants for the RedMulE tile scheduler.
package redmule_pkg;

  typedef enum logic [1:0] {
    TS_IDLE   = 2'd0,
    TS_ISSUE  = 2'd1,
    TS_DRAIN  = 2'd2,
    TS_FINISH = 2'd3
  } tile_sched_state_e;

  localparam int unsigned EXP_STRIDE = 64;

endpackage

// File: rtl/redmule_tile_credit_counter.sv
// Outstanding-request credit pool: take on issue, give on completion.
module redmule_tile_credit_counter #(
  parameter int unsigned MAX = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic take,
  input  logic give,
  output logic avail,
  output logic full,
  output logic err
);

  localparam int unsigned CW = $clog2(MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign full  = (cnt_q == CW'(MAX));
  assign avail = (cnt_q != '0);
  // A completion with nothing outstanding is dropped and flagged.
  assign err   = give && !take && full;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = CW'(MAX);
    end else if (take && !give) begin
      cnt_d = cnt_q - CW'(1);
    end else if (give && !take && !full) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= CW'(MAX);
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/redmule_tile_scheduler.sv
// Walks the col/w/row tile loops and issues credit-limited memory requests.
// Optional exponent addressing enabled by REDMULE_TILE_SCHED_MX_EN.
module redmule_tile_scheduler
  import redmule_pkg::*;
#(
  parameter int unsigned W               = 12,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned JMP             = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] x_base_i,
  input  logic [ADDR_W-1:0] x_rows_offs_i,
  input  logic [CNT_W-1:0]  cols_iters_i,
  input  logic [CNT_W-1:0]  w_iters_i,
  input  logic [CNT_W-1:0]  rows_iters_i,
  input  logic [7:0]        leftover_rows_i,
  input  logic [ADDR_W-1:0] exp_base_i,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic [ADDR_W-1:0] req_addr_o,
  output logic [7:0]        req_len_o,
  output logic              req_last_o,
  output logic [ADDR_W-1:0] exp_addr_o,
  input  logic              done_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  tile_sched_state_e state_q, state_d;
  logic [CNT_W-1:0]  col_q, col_d, w_q, w_d, row_q, row_d;
  logic [ADDR_W-1:0] cols_offs_q, cols_offs_d, rows_offs_q, rows_offs_d;
  logic              err_q, err_d;
  logic              credit_avail, credit_full, credit_err;
  logic              col_max, w_max, row_max, any_zero, xfer;

  assign col_max  = (col_q == cols_iters_i - CNT_W'(1));
  assign w_max    = (w_q == w_iters_i - CNT_W'(1));
  assign row_max  = (row_q == rows_iters_i - CNT_W'(1));
  assign any_zero = (cols_iters_i == '0) || (w_iters_i == '0) || (rows_iters_i == '0);

  assign req_valid_o = (state_q == TS_ISSUE) && credit_avail;
  assign xfer        = req_valid_o && req_ready_i;
  assign req_addr_o  = x_base_i + rows_offs_q + cols_offs_q;
  assign req_len_o   = (row_max && (leftover_rows_i != '0)) ? leftover_rows_i : 8'(W);
  assign req_last_o  = (state_q == TS_ISSUE) && col_max && w_max && row_max;
  assign busy_o      = (state_q == TS_ISSUE) || (state_q == TS_DRAIN);
  assign done_o      = (state_q == TS_FINISH);
  assign err_o       = err_q;

  redmule_tile_credit_counter #(
    .MAX (MAX_OUTSTANDING)
  ) u_credit (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .take    (xfer),
    .give    (done_i),
    .avail   (credit_avail),
    .full    (credit_full),
    .err     (credit_err)
  );

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    w_d         = w_q;
    row_d       = row_q;
    cols_offs_d = cols_offs_q;
    rows_offs_d = rows_offs_q;
    err_d       = err_q | credit_err;
    if (clear_i) begin
      state_d     = TS_IDLE;
      col_d       = '0;
      w_d         = '0;
      row_d       = '0;
      cols_offs_d = '0;
      rows_offs_d = '0;
      err_d       = 1'b0;
    end else begin
      case (state_q)
        TS_IDLE: begin
          if (start_i) begin
            // Starting clears the sticky error, but a same-cycle spurious completion still counts.
            err_d       = credit_err;
            col_d       = '0;
            w_d         = '0;
            row_d       = '0;
            cols_offs_d = '0;
            rows_offs_d = '0;
            state_d     = any_zero ? TS_FINISH : TS_ISSUE;
          end
        end
        TS_ISSUE: begin
          if (xfer) begin
            if (col_max) begin
              col_d       = '0;
              cols_offs_d = '0;
              if (w_max) begin
                w_d = '0;
                if (row_max) begin
                  row_d       = '0;
                  rows_offs_d = '0;
                end else begin
                  row_d       = row_q + CNT_W'(1);
                  rows_offs_d = rows_offs_q + x_rows_offs_i;
                end
              end else begin
                w_d = w_q + CNT_W'(1);
              end
            end else begin
              col_d       = col_q + CNT_W'(1);
              cols_offs_d = cols_offs_q + ADDR_W'(JMP);
            end
            if (req_last_o) begin
              state_d = TS_DRAIN;
            end
          end
        end
        TS_DRAIN: begin
          if (credit_full) begin
            state_d = TS_FINISH;
          end
        end
        TS_FINISH: state_d = TS_IDLE;
        default:   state_d = TS_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= TS_IDLE;
      col_q       <= '0;
      w_q         <= '0;
      row_q       <= '0;
      cols_offs_q <= '0;
      rows_offs_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      w_q         <= w_d;
      row_q       <= row_d;
      cols_offs_q <= cols_offs_d;
      rows_offs_q <= rows_offs_d;
      err_q       <= err_d;
    end
  end

`ifdef REDMULE_TILE_SCHED_MX_EN
  logic [ADDR_W-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clear_i || ((state_q == TS_IDLE) && start_i)) begin
      idx_d = '0;
    end else if (xfer) begin
      idx_d = idx_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign exp_addr_o = (state_q == TS_ISSUE) ? exp_base_i + idx_q * ADDR_W'(EXP_STRIDE) : '0;
`else
  logic unused_exp_base;
  assign unused_exp_base = ^exp_base_i;
  assign exp_addr_o      = '0;
`endif

endmodule

// File: tb/tb_redmule_tile_scheduler.sv
// Bench for redmule_tile_scheduler: transaction-level model plus directed literal checks.
module tb_redmule_tile_scheduler;

  localparam int MAXO = 2;
  localparam int WW   = 12;
  localparam int JMPB = 64;
`ifdef REDMULE_TILE_SCHED_MX_EN
  localparam bit MX = 1'b1;
`else
  localparam bit MX = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_ni, clear_i, start_i, req_ready_i, done_i;
  logic [31:0] x_base_i, x_rows_offs_i, exp_base_i;
  logic [15:0] cols_iters_i, w_iters_i, rows_iters_i;
  logic [7:0]  leftover_rows_i;
  logic        req_valid_o, req_last_o, busy_o, done_o, err_o;
  logic [31:0] req_addr_o, exp_addr_o;
  logic [7:0]  req_len_o;

  always #5 clk = ~clk;

  redmule_tile_scheduler #(
    .W               (WW),
    .MAX_OUTSTANDING (MAXO),
    .ADDR_W          (32),
    .CNT_W           (16),
    .JMP             (JMPB)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .clear_i         (clear_i),
    .start_i         (start_i),
    .x_base_i        (x_base_i),
    .x_rows_offs_i   (x_rows_offs_i),
    .cols_iters_i    (cols_iters_i),
    .w_iters_i       (w_iters_i),
    .rows_iters_i    (rows_iters_i),
    .leftover_rows_i (leftover_rows_i),
    .exp_base_i      (exp_base_i),
    .req_valid_o     (req_valid_o),
    .req_ready_i     (req_ready_i),
    .req_addr_o      (req_addr_o),
    .req_len_o       (req_len_o),
    .req_last_o      (req_last_o),
    .exp_addr_o      (exp_addr_o),
    .done_i          (done_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .err_o           (err_o)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Model: job phase, outstanding count, planned transfer list.
  int          ph, outst, sent, total;
  bit          m_err;
  logic [31:0] e_addr[$];
  logic [7:0]  e_len[$];
  bit          e_last[$];
  logic [31:0] obs_addr[$];
  logic [7:0]  obs_len[$];
  bit          obs_last[$];
  int          n_done_o;
  bit          seen_xfer, d1, d2, auto_done, man_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic plan();
    e_addr.delete(); e_len.delete(); e_last.delete();
    total = int'(cols_iters_i) * int'(w_iters_i) * int'(rows_iters_i);
    for (int r = 0; r < int'(rows_iters_i); r++)
      for (int wi = 0; wi < int'(w_iters_i); wi++)
        for (int c = 0; c < int'(cols_iters_i); c++) begin
          e_addr.push_back(x_base_i + 32'(r) * x_rows_offs_i + 32'(c * JMPB));
          e_len.push_back((r == int'(rows_iters_i) - 1 && leftover_rows_i != 0) ? leftover_rows_i : 8'(WW));
          e_last.push_back(r == int'(rows_iters_i) - 1 && wi == int'(w_iters_i) - 1 &&
                           c == int'(cols_iters_i) - 1);
        end
  endtask

  task automatic monitor();
    bit ev, xf, spur;
    int old_out;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        ph = 0; outst = 0; sent = 0; m_err = 0; seen_xfer = 0;
        chk("rst_valid", req_valid_o, 0);
        chk("rst_last", req_last_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_exp", exp_addr_o, 0);
        continue;
      end
      ev = (ph == 1) && (outst < MAXO);
      chk("valid", req_valid_o, ev);
      chk("busy", busy_o, (ph == 1) || (ph == 2));
      chk("done", done_o, ph == 3);
      chk("err", err_o, m_err);
      if (ev && req_valid_o && sent < total) begin
        chk("addr", req_addr_o, e_addr[sent]);
        chk("len", req_len_o, e_len[sent]);
        chk("last", req_last_o, e_last[sent]);
        chk("exp", exp_addr_o, MX ? exp_base_i + 32'(64 * sent) : 32'h0);
      end
      seen_xfer = req_valid_o && req_ready_i;
      if (seen_xfer) begin
        obs_addr.push_back(req_addr_o);
        obs_len.push_back(req_len_o);
        obs_last.push_back(req_last_o);
      end
      if (done_o) n_done_o++;
      xf      = ev && req_ready_i;
      spur    = done_i && (outst == 0) && !xf;
      old_out = outst;
      if (clear_i) begin
        ph = 0; outst = 0; m_err = 0;
      end else begin
        if (ph == 0 && start_i) m_err = spur;
        else if (spur)          m_err = 1;
        outst = outst + int'(xf) - int'(done_i && !spur);
        case (ph)
          0: if (start_i) begin plan(); sent = 0; ph = (total == 0) ? 3 : 1; end
          1: if (xf) begin sent++; if (sent == total) ph = 2; end
          2: if (old_out == 0) ph = 3;
          default: ph = 0;
        endcase
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    done_i = auto_done ? d2 : man_done;
    d2 = d1;
    d1 = seen_xfer;
  endtask

  task automatic flush();
    d1 = 0; d2 = 0; man_done = 0;
  endtask

  task automatic cfg(input int c, input int w, input int r, input logic [31:0] base,
                     input logic [31:0] roffs, input logic [7:0] left, input logic [31:0] eb);
    cols_iters_i = 16'(c); w_iters_i = 16'(w); rows_iters_i = 16'(r);
    x_base_i = base; x_rows_offs_i = roffs; leftover_rows_i = left; exp_base_i = eb;
    obs_addr.delete(); obs_len.delete(); obs_last.delete();
  endtask

  task automatic start_job();
    start_i = 1; step(); start_i = 0;
  endtask

  task automatic wait_done(input string nm, input bit manual);
    int base = n_done_o;
    for (int i = 0; i < 300 && n_done_o == base; i++) begin
      if (manual) man_done = (outst > 0) && !man_done;
      step();
    end
    man_done = 0;
    chk(nm, n_done_o - base, 1);
  endtask

  logic [31:0] lit_a [8] = '{32'h1000, 32'h1040, 32'h1000, 32'h1040,
                             32'h1400, 32'h1440, 32'h1400, 32'h1440};

  initial begin
    int nd;
    rst_ni = 0; clear_i = 0; start_i = 0; req_ready_i = 1; done_i = 0;
    auto_done = 1; man_done = 0; d1 = 0; d2 = 0; n_done_o = 0;
    ph = 0; outst = 0; sent = 0; total = 0; m_err = 0; seen_xfer = 0;
    cfg(1, 1, 1, 32'h0, 32'h0, 8'd0, 32'h0);
    fork monitor(); join_none
    repeat (3) step();
    rst_ni = 1;
    step();

    // 2x2x2 walk with completions two cycles after each transfer
    cfg(2, 2, 2, 32'h1000, 32'h400, 8'd0, 32'h8000);
    start_job();
    wait_done("A_done", 0);
    chk("A_count", obs_addr.size(), 8);
    for (int i = 0; i < 8 && i < obs_addr.size(); i++) begin
      chk($sformatf("A_addr%0d", i), obs_addr[i], lit_a[i]);
      chk($sformatf("A_last%0d", i), obs_last[i], i == 7);
    end
    nd = n_done_o;
    repeat (5) step();
    chk("A_single_done", n_done_o - nd, 0);

    // Leftover rows on the last row tile
    cfg(1, 1, 3, 32'h0, 32'h100, 8'd5, 32'h0);
    start_job();
    wait_done("B_done", 0);
    chk("B_len0", obs_len.size() > 0 ? obs_len[0] : 8'hff, 12);
    chk("B_len1", obs_len.size() > 1 ? obs_len[1] : 8'hff, 12);
    chk("B_len2", obs_len.size() > 2 ? obs_len[2] : 8'hff, 5);
    cfg(1, 1, 3, 32'h0, 32'h100, 8'd0, 32'h0);
    start_job();
    wait_done("B0_done", 0);
    chk("B0_len2", obs_len.size() > 2 ? obs_len[2] : 8'hff, 12);

    // Credits exhausted with completions withheld
    auto_done = 0; flush();
    cfg(4, 1, 1, 32'h2000, 32'h0, 8'd0, 32'h0);
    start_job();
    repeat (10) step();
    chk("C_two_xfers", obs_addr.size(), 2);
    chk("C_stalled", req_valid_o, 0);
    man_done = 1; step(); man_done = 0;
    repeat (10) step();
    chk("C_one_more", obs_addr.size(), 3);
    wait_done("C_done", 1);

    // Transfer and completion in the same cycle keep credits level
    cfg(4, 1, 1, 32'h3000, 32'h0, 8'd0, 32'h0);
    start_i = 1; step(); start_i = 0;
    man_done = 1; step(); man_done = 0;
    repeat (4) step();
    chk("D_xfers", obs_addr.size(), 3);
    chk("D_stalled", req_valid_o, 0);
    wait_done("D_done", 1);
    man_done = 1; step(); man_done = 0;
    step(); step();
    chk("D_spurious_err", err_o, 1);
    cfg(0, 1, 1, 32'h0, 32'h0, 8'd0, 32'h0);
    start_job();
    chk("D_err_cleared", err_o, 0);
    chk("Z_done_pulse", done_o, 1);
    chk("Z_not_busy", busy_o, 0);
    step();
    chk("Z_no_xfer", obs_addr.size(), 0);

    // Backpressure: payload must hold while ready is low
    auto_done = 1; flush();
    cfg(3, 1, 2, 32'h4000, 32'h80, 8'd3, 32'h100);
    start_i = 1; step(); start_i = 0;
    for (int i = 0; i < 300 && n_done_o == nd + 0 && obs_addr.size() < 6; i++) begin
      req_ready_i = (i % 3) != 0;
      step();
    end
    req_ready_i = 1;
    wait_done("G_done", 0);
    chk("G_count", obs_addr.size(), 6);

    // Clear with start mid-issue abandons the job
    cfg(4, 2, 1, 32'h5000, 32'h0, 8'd0, 32'h0);
    start_job();
    repeat (2) step();
    nd = n_done_o;
    clear_i = 1; start_i = 1; step(); clear_i = 0; start_i = 0; auto_done = 0; flush();
    chk("E_not_busy", busy_o, 0);
    chk("E_no_done", done_o, 0);
    chk("E_not_valid", req_valid_o, 0);
    repeat (5) step();
    chk("E_no_later_done", n_done_o - nd, 0);
    auto_done = 1;
    cfg(2, 1, 1, 32'h6000, 32'h0, 8'd0, 32'h2000);
    start_job();
    chk("E_first_exp", exp_addr_o, MX ? 32'h2000 : 32'h0);
    wait_done("E_fresh_done", 0);

    // Reset mid-job: no completion pulse afterwards
    cfg(4, 2, 2, 32'h7000, 32'h200, 8'd0, 32'h0);
    start_job();
    repeat (3) step();
    nd = n_done_o;
    rst_ni = 0; step(); rst_ni = 1; flush(); auto_done = 0;
    repeat (10) step();
    chk("R_no_done", n_done_o - nd, 0);
    chk("R_idle", busy_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
